// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter that lets NUM_REQ requesters share one
// load-enabled register. Each grant drives one load cycle, checks the readback
// on the following cycle, and then pulses ack with a pass/fail flag on err.
// Optional build macro REG_ARB_LOCK_EN adds a 'lock' input. When lock is set,
// the owner holding lock in CHECK is re-granted in the next IDLE.
module reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int IDW     = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        err,
  output logic                        busy,
  output logic [IDW-1:0]              grant_id,
  output logic                        reg_load,
  output logic [DATA_W-1:0]           reg_data,
`ifdef REG_ARB_LOCK_EN
  input  logic                        lock,
`endif
  input  logic [DATA_W-1:0]           reg_q
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      grant_id_q, grant_id_d;
  logic [IDW-1:0]      last_q, last_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   reg_data_q, reg_data_d;
  logic                reg_load_q, reg_load_d;
  logic                busy_q, busy_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
`ifdef REG_ARB_LOCK_EN
  logic                lock_pend_q, lock_pend_d;
`endif

  logic [IDW-1:0]        rr_idx_s;
  logic [2*NUM_REQ-1:0]  rr_rot_s;
  int                    rr_base_s;
  int                    rr_win_s;
  logic [DATA_W-1:0]     rr_data_s;
  logic [DATA_W-1:0]     gid_data_s;
  logic                  gid_req_s;
  logic [NUM_REQ-1:0]    gid_onehot_s;

  // Round-robin search: rotate requests so last_winner+1 lands at bit 0,
  // then the lowest set bit of the rotated vector is the winner.
  always_comb begin
    rr_base_s = int'(last_q) + 1;
    if (rr_base_s >= NUM_REQ) begin
      rr_base_s = rr_base_s - NUM_REQ;
    end else begin
      rr_base_s = rr_base_s;
    end
    rr_rot_s = {req, req} >> rr_base_s;
    rr_win_s = rr_base_s;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rr_rot_s[j]) begin
        rr_win_s = rr_base_s + j;
      end else begin
        rr_win_s = rr_win_s;
      end
    end
    if (rr_win_s >= NUM_REQ) begin
      rr_win_s = rr_win_s - NUM_REQ;
    end else begin
      rr_win_s = rr_win_s;
    end
    rr_idx_s = IDW'(rr_win_s);
  end

  // Per-index lookups done with constant selects: winner data, current
  // owner's data/request, and the one-hot ack pattern for the current owner.
  always_comb begin
    rr_data_s    = {DATA_W{1'b0}};
    gid_data_s   = {DATA_W{1'b0}};
    gid_req_s    = 1'b0;
    gid_onehot_s = {NUM_REQ{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDW'(k) == rr_idx_s) begin
        rr_data_s = req_data[k*DATA_W +: DATA_W];
      end else begin
        rr_data_s = rr_data_s;
      end
      if (IDW'(k) == grant_id_q) begin
        gid_data_s      = req_data[k*DATA_W +: DATA_W];
        gid_req_s       = req[k];
        gid_onehot_s[k] = 1'b1;
      end else begin
        gid_onehot_s[k] = 1'b0;
      end
    end
  end

  // Next-state and next-output computation for the IDLE/LOAD/CHECK sequence.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    last_d      = last_q;
    hold_d      = hold_q;
    reg_data_d  = reg_data_q;
    reg_load_d  = 1'b0;
    busy_d      = busy_q;
    ack_d       = {NUM_REQ{1'b0}};
`ifdef REG_ARB_LOCK_EN
    lock_pend_d = lock_pend_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef REG_ARB_LOCK_EN
        if (lock_pend_q) begin
          // Locked re-grant: same owner, last_winner left untouched.
          state_d     = ST_LOAD;
          hold_d      = gid_data_s;
          reg_data_d  = gid_data_s;
          reg_load_d  = 1'b1;
          busy_d      = 1'b1;
          lock_pend_d = 1'b0;
        end else
`endif
        if (|req) begin
          state_d    = ST_LOAD;
          grant_id_d = rr_idx_s;
          last_d     = rr_idx_s;
          hold_d     = rr_data_s;
          reg_data_d = rr_data_s;
          reg_load_d = 1'b1;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        state_d = ST_CHECK;
        busy_d  = 1'b1;
        ack_d   = gid_onehot_s;
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
`ifdef REG_ARB_LOCK_EN
        lock_pend_d = lock & gid_req_s;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset aborts any
  // in-flight transaction and re-arms requester 0 as first priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      grant_id_q  <= {IDW{1'b0}};
      last_q      <= IDW'(NUM_REQ - 1);
      hold_q      <= {DATA_W{1'b0}};
      reg_data_q  <= {DATA_W{1'b0}};
      reg_load_q  <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= {NUM_REQ{1'b0}};
`ifdef REG_ARB_LOCK_EN
      lock_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      reg_data_q  <= reg_data_d;
      reg_load_q  <= reg_load_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
`ifdef REG_ARB_LOCK_EN
      lock_pend_q <= lock_pend_d;
`endif
    end
  end

  // The shared register only updates at the end of LOAD, so the readback
  // compare must see reg_q live during CHECK; err is gated by ack.
  assign err      = (|ack_q) & (reg_q != hold_q);
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;
  assign reg_load = reg_load_q;
  assign reg_data = reg_data_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter with a behavioural
// shared register on the reg_load/reg_data/reg_q loop.
module tb_reg_write_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  ack;
  logic        err;
  logic        busy;
  logic [1:0]  grant_id;
  logic        reg_load;
  logic [7:0]  reg_data;
  logic [7:0]  reg_q;
  logic [7:0]  reg_sh = 8'h00;
  logic        force_bad = 1'b0;
`ifdef REG_ARB_LOCK_EN
  logic        lock = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  reg_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .IDW(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .err      (err),
    .busy     (busy),
    .grant_id (grant_id),
    .reg_load (reg_load),
    .reg_data (reg_data),
`ifdef REG_ARB_LOCK_EN
    .lock     (lock),
`endif
    .reg_q    (reg_q)
  );

  always #5 CLK = ~CLK;

  // Behavioural shared register; readback can be forced wrong.
  always_ff @(posedge CLK) begin
    if (reg_load) reg_sh <= reg_data;
  end
  assign reg_q = force_bad ? 8'h00 : reg_sh;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1: reset state, then single write from requester 0
    do_reset();
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_load", 32'(reg_load), 32'h0);
    check("rst_data", 32'(reg_data), 32'h0);
    check("rst_gid", 32'(grant_id), 32'h0);
    req = 4'b0001;
    req_data[7:0] = 8'hA5;
    tick();
    check("t1_load", 32'(reg_load), 32'h1);
    check("t1_data", 32'(reg_data), 32'hA5);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_ack_load", 32'(ack), 32'h0);
    tick();
    check("t1_ack", 32'(ack), 32'h1);
    check("t1_err", 32'(err), 32'h0);
    check("t1_gid", 32'(grant_id), 32'h0);
    check("t1_load_chk", 32'(reg_load), 32'h0);
    req = 4'b0000;
    tick();
    check("t1_idle_ack", 32'(ack), 32'h0);
    check("t1_idle_busy", 32'(busy), 32'h0);
    check("t1_hold_data", 32'(reg_data), 32'hA5);

    // Test 2: all requesting, round-robin order 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    req_data = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_gid", 32'(grant_id), 32'(k % 4));
      check("t2_data", 32'(reg_data), 32'h10 + 32'(k % 4));
      check("t2_load", 32'(reg_load), 32'h1);
      tick();
      check("t2_ack", 32'(ack), 32'h1 << (k % 4));
      check("t2_err", 32'(err), 32'h0);
      if (k == 4) req = 4'b0000;
      tick();
      check("t2_gap_ack", 32'(ack), 32'h0);
    end
    check("t2_idle_busy", 32'(busy), 32'h0);

    // Test 3: forced readback mismatch, then a clean write
    do_reset();
    force_bad = 1'b1;
    req = 4'b0001;
    req_data[7:0] = 8'h5A;
    tick();
    check("t3_data", 32'(reg_data), 32'h5A);
    tick();
    check("t3_ack_bad", 32'(ack), 32'h1);
    check("t3_err_bad", 32'(err), 32'h1);
    force_bad = 1'b0;
    tick();
    tick();
    check("t3_regrant", 32'(reg_load), 32'h1);
    tick();
    check("t3_ack_ok", 32'(ack), 32'h1);
    check("t3_err_ok", 32'(err), 32'h0);
    req = 4'b0000;
    tick();
    check("t3_idle_err", 32'(err), 32'h0);

    // Test 4: reset during LOAD aborts, requester 2 served afterwards
    req = 4'b0100;
    req_data[23:16] = 8'h77;
    tick();
    check("t4_gid", 32'(grant_id), 32'h2);
    check("t4_load", 32'(reg_load), 32'h1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t4_rst_ack", 32'(ack), 32'h0);
    check("t4_rst_busy", 32'(busy), 32'h0);
    check("t4_rst_load", 32'(reg_load), 32'h0);
    check("t4_rst_gid", 32'(grant_id), 32'h0);
    tick();
    check("t4_gid2", 32'(grant_id), 32'h2);
    check("t4_data2", 32'(reg_data), 32'h77);
    tick();
    check("t4_ack", 32'(ack), 32'h4);
    check("t4_err", 32'(err), 32'h0);
    req = 4'b0000;
    tick();

    // Test 5: data captured at grant; dropping req still completes
    req = 4'b0010;
    req_data[15:8] = 8'h33;
    tick();
    check("t5_data", 32'(reg_data), 32'h33);
    check("t5_gid", 32'(grant_id), 32'h1);
    req_data[15:8] = 8'hCC;
    req = 4'b0000;
    tick();
    check("t5_ack", 32'(ack), 32'h2);
    check("t5_err", 32'(err), 32'h0);
    tick();
    check("t5_idle_ack", 32'(ack), 32'h0);
    check("t5_hold_data", 32'(reg_data), 32'h33);
    check("t5_busy", 32'(busy), 32'h0);

`ifdef REG_ARB_LOCK_EN
    // Test 6: lock in CHECK re-grants requester 0, then round-robin resumes
    do_reset();
    req = 4'b0011;
    req_data[15:0] = 16'h4140;
    tick();
    check("t6_gid_a", 32'(grant_id), 32'h0);
    tick();
    check("t6_ack_a", 32'(ack), 32'h1);
    lock = 1'b1;
    tick();
    lock = 1'b0;
    tick();
    check("t6_gid_b", 32'(grant_id), 32'h0);
    check("t6_data_b", 32'(reg_data), 32'h40);
    tick();
    check("t6_ack_b", 32'(ack), 32'h1);
    tick();
    tick();
    check("t6_gid_c", 32'(grant_id), 32'h1);
    check("t6_data_c", 32'(reg_data), 32'h41);
    tick();
    check("t6_ack_c", 32'(ack), 32'h2);
    req = 4'b0000;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
